// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_REG_WIDTH  = 5;
    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned NUM_REGS       = 32;

    typedef logic [DEF_REG_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/wb_scoreboard.sv
// 32-entry busy scoreboard for destinations of in-flight long-latency ops.
module wb_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned REG_WIDTH = DEF_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_en,
    input  logic [REG_WIDTH-1:0] clr_idx,
    input  logic                 set_en,
    input  logic [REG_WIDTH-1:0] set_idx,
    input  logic [REG_WIDTH-1:0] rs1,
    input  logic [REG_WIDTH-1:0] rs2,
    input  logic [REG_WIDTH-1:0] rd,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 hazard
);

    logic [NUM_REGS-1:0] busy_next;

    // Clear is applied before set so a same-cycle return/issue pair leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_idx] = 1'b0;
        if (set_en && set_idx != '0) busy_next[set_idx] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    assign hazard = busy[rs1] | busy[rs2] | busy[rd];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between core writeback and the long-latency unit.
// Optional LU starvation guard enabled by defining WB_ARB_FAIRNESS_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] IDU_i_rs1,
    input  logic [REG_WIDTH-1:0] IDU_i_rs2,
    input  logic [REG_WIDTH-1:0] IDU_i_rd,
    input  logic                 CTRL_i_reg_wen,
    input  logic                 CTRL_i_lu_issue,
    input  logic [WIDTH-1:0]     WBU_i_valW,
    input  logic                 LU_i_valid,
    input  logic [REG_WIDTH-1:0] LU_i_rd,
    input  logic [WIDTH-1:0]     LU_i_data,
    output logic                 LU_o_ready,
    output logic                 ARB_o_reg_wen,
    output logic [REG_WIDTH-1:0] ARB_o_rd,
    output logic [WIDTH-1:0]     ARB_o_valW,
    output logic                 ARB_o_stall,
    output logic [NUM_REGS-1:0]  ARB_o_busy
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    logic hazard_raw;
    logic hazard;
    logic starve_hit;
    logic lu_grant;
    logic core_write;
    logic issue_set;

    wb_scoreboard #(.REG_WIDTH(REG_WIDTH)) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .clr_en  (lu_grant),
        .clr_idx (LU_i_rd),
        .set_en  (issue_set),
        .set_idx (IDU_i_rd),
        .rs1     (IDU_i_rs1),
        .rs2     (IDU_i_rs2),
        .rd      (IDU_i_rd),
        .busy    (ARB_o_busy),
        .hazard  (hazard_raw)
    );

    // Every control term is masked by rst so the port is quiet while reset is held.
    always_comb begin
        hazard      = hazard_raw & ~rst;
        lu_grant    = ~rst & LU_i_valid & (~CTRL_i_reg_wen | hazard | starve_hit);
        ARB_o_stall = hazard | (lu_grant & CTRL_i_reg_wen);
        core_write  = ~rst & CTRL_i_reg_wen & ~ARB_o_stall;
        issue_set   = ~rst & CTRL_i_lu_issue & ~ARB_o_stall;
        LU_o_ready  = lu_grant;
    end

    always_comb begin
        ARB_o_reg_wen = 1'b0;
        ARB_o_rd      = '0;
        ARB_o_valW    = '0;
        if (lu_grant) begin
            ARB_o_reg_wen = (LU_i_rd != '0);
            ARB_o_rd      = LU_i_rd;
            ARB_o_valW    = LU_i_data;
        end else if (core_write) begin
            ARB_o_reg_wen = (IDU_i_rd != '0);
            ARB_o_rd      = IDU_i_rd;
            ARB_o_valW    = WBU_i_valW;
        end
    end

`ifdef WB_ARB_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX) + 1;

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst)                         starve_cnt <= '0;
        else if (!LU_i_valid || lu_grant) starve_cnt <= '0;
        else if (starve_cnt != '1)       starve_cnt <= starve_cnt + 1'b1;
    end

    assign starve_hit = (starve_cnt >= CNT_W'(STARVE_MAX));
`else
    assign starve_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter; starvation expectations follow WB_ARB_FAIRNESS_EN.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        wen = 1'b0, issue = 1'b0;
    logic [31:0] wb = '0;
    logic        luv = 1'b0;
    logic [4:0]  lurd = '0;
    logic [31:0] ludata = '0;

    logic        lu_ready, arb_wen, arb_stall;
    logic [4:0]  arb_rd;
    logic [31:0] arb_val, arb_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .IDU_i_rs1      (rs1),
        .IDU_i_rs2      (rs2),
        .IDU_i_rd       (rd),
        .CTRL_i_reg_wen (wen),
        .CTRL_i_lu_issue(issue),
        .WBU_i_valW     (wb),
        .LU_i_valid     (luv),
        .LU_i_rd        (lurd),
        .LU_i_data      (ludata),
        .LU_o_ready     (lu_ready),
        .ARB_o_reg_wen  (arb_wen),
        .ARB_o_rd       (arb_rd),
        .ARB_o_valW     (arb_val),
        .ARB_o_stall    (arb_stall),
        .ARB_o_busy     (arb_busy)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, issue;
        logic [31:0] wb;
        logic        luv;
        logic [4:0]  lurd;
        logic [31:0] ludata;
        logic        e_ready, e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                                logic w, logic i, logic [31:0] v, logic lv, logic [4:0] lr,
                                logic [31:0] ld, logic er, logic ew, logic [4:0] ed,
                                logic [31:0] ev, logic es, logic [31:0] eb);
        vec_t t;
        t.rst = r; t.rs1 = a; t.rs2 = b; t.rd = d; t.wen = w; t.issue = i; t.wb = v;
        t.luv = lv; t.lurd = lr; t.ludata = ld;
        t.e_ready = er; t.e_wen = ew; t.e_rd = ed; t.e_val = ev; t.e_stall = es; t.e_busy = eb;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic er, input logic ew, input logic [4:0] ed,
                             input logic [31:0] ev, input logic es, input logic [31:0] eb);
        check("lu_ready", idx, 32'(lu_ready), 32'(er));
        check("reg_wen",  idx, 32'(arb_wen),  32'(ew));
        check("rd",       idx, 32'(arb_rd),   32'(ed));
        check("valW",     idx, arb_val,       ev);
        check("stall",    idx, 32'(arb_stall), 32'(es));
        check("busy",     idx, arb_busy,      eb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=-1 got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic fair;
`ifdef WB_ARB_FAIRNESS_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        //              rst rs1 rs2 rd  wen iss wb            luv lurd ludata        rdy wen rd  val           stl busy
        vecs.push_back(mk(1, 0,  0,  4,  1,  0, 32'h0000_0044, 1,  3,  32'h0000_0033, 0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 1,  2,  5,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 5,  0,  6,  1,  0, 32'h0000_0011, 0,  0,  32'h0,         0,  0,  0,  32'h0,        1,  32'h20));
        vecs.push_back(mk(0, 5,  0,  6,  1,  0, 32'h0000_0011, 0,  0,  32'h0,         0,  0,  0,  32'h0,        1,  32'h20));
        vecs.push_back(mk(0, 5,  0,  0,  0,  0, 32'h0,         1,  5,  32'hDEAD_BEEF, 1,  1,  5,  32'hDEAD_BEEF, 1, 32'h20));
        vecs.push_back(mk(0, 5,  0,  0,  0,  0, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 1,  2,  3,  1,  0, 32'h0000_0033, 1,  7,  32'h0000_0077, 0,  1,  3,  32'h0000_0033, 0, 32'h0));
        vecs.push_back(mk(0, 1,  2,  3,  0,  0, 32'h0000_0033, 1,  7,  32'h0000_0077, 1,  1,  7,  32'h0000_0077, 0, 32'h0));
        vecs.push_back(mk(0, 0,  0,  0,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 32'h0,         1,  0,  32'h0000_0099, 1,  0,  0,  32'h0000_0099, 0, 32'h0));
        vecs.push_back(mk(0, 0,  0,  9,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 9,  0, 10,  1,  0, 32'h0000_00AA, 1,  9,  32'h0000_1234, 1,  1,  9,  32'h0000_1234, 1, 32'h200));
        vecs.push_back(mk(0, 9,  0, 10,  1,  0, 32'h0000_00AA, 0,  0,  32'h0,         0,  1, 10,  32'h0000_00AA, 0, 32'h0));
        vecs.push_back(mk(0, 0,  0, 12,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 0,  0, 12,  1,  0, 32'h0000_0005, 0,  0,  32'h0,         0,  0,  0,  32'h0,        1,  32'h1000));
        vecs.push_back(mk(0, 12, 0, 13,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        1,  32'h1000));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 32'h0,         1, 12,  32'h0000_000C, 1,  1, 12,  32'h0000_000C, 0, 32'h1000));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 0,  0,  5,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));
        vecs.push_back(mk(0, 0,  0,  6,  0,  1, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h20));
        vecs.push_back(mk(1, 5,  0,  5,  1,  1, 32'h0000_0055, 1,  5,  32'h0000_5555, 0,  0,  0,  32'h0,        0,  32'h60));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 32'h0,         0,  0,  32'h0,         0,  0,  0,  32'h0,        0,  32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
            wen = vecs[i].wen; issue = vecs[i].issue; wb = vecs[i].wb;
            luv = vecs[i].luv; lurd = vecs[i].lurd; ludata = vecs[i].ludata;
            #1;
            check_all(i, vecs[i].e_ready, vecs[i].e_wen, vecs[i].e_rd, vecs[i].e_val,
                      vecs[i].e_stall, vecs[i].e_busy);
        end

        // LU held behind back-to-back core writes over two rounds; a forced grant
        // (fairness build) must land on the 5th waiting cycle and restart the count.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 5; c++) begin
                logic g;
                @(negedge clk);
                rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; wen = 1'b1; issue = 1'b0;
                wb = 32'h0000_0300 + 32'(c); luv = 1'b1; lurd = 5'd7; ludata = 32'h0000_7777;
                #1;
                g = fair && (c == 4);
                check_all(100 + r * 10 + c, g, 1'b1, g ? 5'd7 : 5'd3,
                          g ? 32'h0000_7777 : 32'h0000_0300 + 32'(c), g, 32'h0);
            end
        end

        @(negedge clk);
        wen = 1'b0; luv = 1'b0;
        #1;
        check_all(200, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
